// File: rtl/round_key_reader_pkg.sv
// Shared key-schedule definitions: default widths, the largest AES round index
// and the sequencer state encoding.
package round_key_reader_pkg;

  localparam int WORD_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 4;

  // AES-256 has 14 rounds, the largest key-schedule index we ever need
  localparam logic [3:0] MAX_ROUND = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_PRESENT = 2'd3
  } state_t;

endpackage

// File: rtl/round_key_reader.sv
// Walks the expanded-key RAM (encrypt or decrypt bank) from round 0 up to the
// requested last round, presenting one four-word round key per handshake.
module round_key_reader
  import round_key_reader_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStart,
  input  logic              iDecrypt,
  input  logic [3:0]        iRound,
  output logic [ADDR_W-1:0] oRAM_Ke_addr,
  input  logic [WORD_W-1:0] iRAM_Ke_data_1,
  input  logic [WORD_W-1:0] iRAM_Ke_data_2,
  input  logic [WORD_W-1:0] iRAM_Ke_data_3,
  input  logic [WORD_W-1:0] iRAM_Ke_data_4,
  output logic [ADDR_W-1:0] oRAM_Kd_addr,
  input  logic [WORD_W-1:0] iRAM_Kd_data_1,
  input  logic [WORD_W-1:0] iRAM_Kd_data_2,
  input  logic [WORD_W-1:0] iRAM_Kd_data_3,
  input  logic [WORD_W-1:0] iRAM_Kd_data_4,
  output logic              oKey_valid,
  input  logic              iKey_ready,
  output logic [WORD_W-1:0] oKey_data_1,
  output logic [WORD_W-1:0] oKey_data_2,
  output logic [WORD_W-1:0] oKey_data_3,
  output logic [WORD_W-1:0] oKey_data_4,
  output logic [3:0]        oKey_round,
  output logic              oKey_last,
  output logic              oBusy
);

  state_t            state;
  state_t            state_nxt;
  logic              decrypt_lat;
  logic [3:0]        round_lat;
  logic [ADDR_W-1:0] addr;

  // Both banks share one address; the bank choice is made on the read data
  assign oRAM_Ke_addr = addr;
  assign oRAM_Kd_addr = addr;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (iStart) state_nxt = ST_FETCH;
      ST_FETCH:   state_nxt = ST_WAIT;
      ST_WAIT:    state_nxt = ST_PRESENT;
      ST_PRESENT: if (iKey_ready) state_nxt = oKey_last ? ST_IDLE : ST_FETCH;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    oKey_valid = (state == ST_PRESENT);
    oBusy      = (state != ST_IDLE);
  end

  // Request parameters are captured once at start; later input changes are ignored
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      decrypt_lat <= 1'b0;
      round_lat   <= 4'd0;
      addr        <= '0;
      oKey_data_1 <= '0;
      oKey_data_2 <= '0;
      oKey_data_3 <= '0;
      oKey_data_4 <= '0;
      oKey_round  <= 4'd0;
      oKey_last   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (iStart) begin
            decrypt_lat <= iDecrypt;
            // Out-of-range requests are capped so the walk stays inside the key table
            round_lat   <= (iRound > MAX_ROUND) ? MAX_ROUND : iRound;
            addr        <= '0;
          end
        end
        ST_WAIT: begin
          oKey_data_1 <= decrypt_lat ? iRAM_Kd_data_1 : iRAM_Ke_data_1;
          oKey_data_2 <= decrypt_lat ? iRAM_Kd_data_2 : iRAM_Ke_data_2;
          oKey_data_3 <= decrypt_lat ? iRAM_Kd_data_3 : iRAM_Ke_data_3;
          oKey_data_4 <= decrypt_lat ? iRAM_Kd_data_4 : iRAM_Ke_data_4;
          oKey_round  <= 4'(addr);
          oKey_last   <= (addr == ADDR_W'(round_lat));
        end
        ST_PRESENT: begin
          if (iKey_ready) begin
            oKey_last <= 1'b0;
            if (!oKey_last) addr <= addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_round_key_reader.sv
// Bench for round_key_reader: synchronous key RAMs, a scoreboard of expected
// round keys and a monitor that checks every presented key.
module tb_round_key_reader;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 4;

  logic              iClk = 1'b0;
  logic              iRst_n = 1'b0;
  logic              iStart = 1'b0;
  logic              iDecrypt = 1'b0;
  logic [3:0]        iRound = 4'd0;
  logic              iKey_ready = 1'b0;
  logic [ADDR_W-1:0] oRAM_Ke_addr, oRAM_Kd_addr;
  logic [WORD_W-1:0] ke_q1, ke_q2, ke_q3, ke_q4;
  logic [WORD_W-1:0] kd_q1, kd_q2, kd_q3, kd_q4;
  logic              oKey_valid, oKey_last, oBusy;
  logic [WORD_W-1:0] oKey_data_1, oKey_data_2, oKey_data_3, oKey_data_4;
  logic [3:0]        oKey_round;

  round_key_reader #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iDecrypt(iDecrypt), .iRound(iRound),
    .oRAM_Ke_addr(oRAM_Ke_addr),
    .iRAM_Ke_data_1(ke_q1), .iRAM_Ke_data_2(ke_q2), .iRAM_Ke_data_3(ke_q3), .iRAM_Ke_data_4(ke_q4),
    .oRAM_Kd_addr(oRAM_Kd_addr),
    .iRAM_Kd_data_1(kd_q1), .iRAM_Kd_data_2(kd_q2), .iRAM_Kd_data_3(kd_q3), .iRAM_Kd_data_4(kd_q4),
    .oKey_valid(oKey_valid), .iKey_ready(iKey_ready),
    .oKey_data_1(oKey_data_1), .oKey_data_2(oKey_data_2), .oKey_data_3(oKey_data_3), .oKey_data_4(oKey_data_4),
    .oKey_round(oKey_round), .oKey_last(oKey_last), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  // Preloaded key tables: Ke[n] = {n, n+16, n+32, n+48}, Kd a distinct pattern
  function automatic logic [127:0] ke_word(input int n);
    return {32'(n), 32'(n + 16), 32'(n + 32), 32'(n + 48)};
  endfunction
  function automatic logic [127:0] kd_word(input int n);
    return {32'hD000_0000 + 32'(n * 256), 32'hD100_0000 + 32'(n * 256),
            32'hD200_0000 + 32'(n * 256), 32'hD300_0000 + 32'(n * 256)};
  endfunction

  // One-cycle read latency RAM models
  always @(posedge iClk) begin
    {ke_q1, ke_q2, ke_q3, ke_q4} <= ke_word(int'(oRAM_Ke_addr));
    {kd_q1, kd_q2, kd_q3, kd_q4} <= kd_word(int'(oRAM_Kd_addr));
  end

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   rnd;
    logic         last;
  } key_t;
  key_t sb[$];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Consumer: random or always-ready, with an optional forced stall on one round
  bit ready_rand  = 1'b0;
  int stall_round = -1;
  int stall_left  = 0;
  always @(posedge iClk) begin
    #1;
    if (stall_left > 0 && oKey_valid && int'(oKey_round) == stall_round) begin
      iKey_ready = 1'b0;
      stall_left--;
    end else begin
      iKey_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: every presented key must match the head of the scoreboard
  always @(negedge iClk) begin
    if (iRst_n && oKey_valid) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_key: round %0d presented, none expected", oKey_round);
      end else begin
        chk("key_data", {oKey_data_1, oKey_data_2, oKey_data_3, oKey_data_4}, sb[0].data);
        chk("key_round", 128'(oKey_round), 128'(sb[0].rnd));
        chk("key_last", 128'(oKey_last), 128'(sb[0].last));
        chk("ram_addr", 128'({oRAM_Ke_addr, oRAM_Kd_addr}),
            128'({ADDR_W'(sb[0].rnd), ADDR_W'(sb[0].rnd)}));
        if (iKey_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic start_seq(input bit dec, input int rnd);
    @(posedge iClk); #1;
    iStart = 1'b1; iDecrypt = dec; iRound = 4'(rnd);
    for (int r = 0; r <= rnd; r++)
      sb.push_back('{data: dec ? kd_word(r) : ke_word(r), rnd: 4'(r), last: (r == rnd)});
    @(posedge iClk); #1;
    // Scramble the request inputs after acceptance; they must have no effect
    iStart = 1'b0; iDecrypt = 1'($urandom); iRound = 4'($urandom);
    @(negedge iClk);
    chk("busy_after_start", 128'(oBusy), 128'(1));
    chk("no_valid_fetch", 128'(oKey_valid), 128'(0));
    @(negedge iClk);
    chk("no_valid_wait", 128'(oKey_valid), 128'(0));
    @(negedge iClk);
    chk("first_valid_latency", 128'(oKey_valid), 128'(1));
  endtask

  task automatic wait_done();
    int n = 0;
    while ((oBusy || sb.size() != 0) && n < 2000) begin
      @(negedge iClk);
      n++;
    end
    chk("busy_end", 128'(oBusy), 128'(0));
    chk("all_keys_seen", 128'(sb.size()), 128'(0));
    chk("valid_end", 128'(oKey_valid), 128'(0));
  endtask

  initial begin
    repeat (3) @(negedge iClk);
    chk("rst_valid_busy_last", 128'({oKey_valid, oBusy, oKey_last}), 128'(0));
    chk("rst_addr_round", 128'({oRAM_Ke_addr, oRAM_Kd_addr, oKey_round}), 128'(0));
    chk("rst_data", {oKey_data_1, oKey_data_2, oKey_data_3, oKey_data_4}, 128'(0));
    iRst_n = 1'b1;

    // Encrypt bank, 11 keys, consumer always ready
    ready_rand = 1'b0;
    start_seq(1'b0, 10);
    wait_done();

    // Decrypt bank, 15 keys
    start_seq(1'b1, 14);
    wait_done();

    // Back-pressure on round 4 for five cycles
    stall_round = 4; stall_left = 5;
    start_seq(1'b0, 12);
    wait_done();
    chk("stall_consumed", 128'(stall_left), 128'(0));
    stall_round = -1;

    // Start pulse with toggled bank while a key is presented is ignored
    start_seq(1'b0, 10);
    iStart = 1'b1; iDecrypt = 1'b1; iRound = 4'd2;
    @(negedge iClk);
    iStart = 1'b0;
    wait_done();

    // Single-key sequence
    start_seq(1'b1, 0);
    wait_done();

    // Random sequences with a random consumer
    ready_rand = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start_seq(1'($urandom), int'($urandom_range(0, 14)));
      wait_done();
    end

    // Reset while the round-3 key is in flight (WAIT), with start held high
    start_seq(1'b1, 12);
    begin
      int n = 0;
      while (!(oRAM_Ke_addr == ADDR_W'(3) && !oKey_valid) && n < 500) begin
        @(negedge iClk);
        n++;
      end
      chk("reach_round3_fetch", 128'(oRAM_Ke_addr), 128'(3));
    end
    @(negedge iClk);
    iRst_n = 1'b0; iStart = 1'b1;
    sb.delete();
    @(negedge iClk);
    chk("abort_valid_busy_last", 128'({oKey_valid, oBusy, oKey_last}), 128'(0));
    chk("abort_addr_round", 128'({oRAM_Ke_addr, oRAM_Kd_addr, oKey_round}), 128'(0));
    chk("abort_data", {oKey_data_1, oKey_data_2, oKey_data_3, oKey_data_4}, 128'(0));
    iRst_n = 1'b1; iStart = 1'b0;
    @(negedge iClk);
    chk("start_in_reset_ignored", 128'(oBusy), 128'(0));
    start_seq(1'b0, 5);
    wait_done();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/round_key_reader.md
ROUND_KEY_READER -- requirements
Module: round_key_reader

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning round-key word width.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning key-RAM address width.
REQ-003 SHALL have one clock; reset is synchronous and active-low. Ports: iClk  in  1  clock; iRst_n  in  1  sync active-low reset.
REQ-004 SHALL have ports: iStart  in  1  begin key sequence; iDecrypt  in  1  1=read m_Kd, 0=read m_Ke; iRound  in  4  last round index (10/12/14).
REQ-005 SHALL have ports: oRAM_Ke_addr  out  ADDR_W  m_Ke read address; iRAM_Ke_data_1..4  in  WORD_W each  m_Ke read words.
REQ-006 SHALL have ports: oRAM_Kd_addr  out  ADDR_W  m_Kd read address; iRAM_Kd_data_1..4  in  WORD_W each  m_Kd read words.
REQ-007 SHALL have ports: oKey_valid  out  1  round key available; iKey_ready  in  1  consumer accepts; oKey_data_1..4  out  WORD_W each  round key words; oKey_round  out  4  round index of key; oKey_last  out  1  final key of sequence; oBusy  out  1  sequence active.

Function
REQ-008 SHALL implement states IDLE, FETCH, WAIT, PRESENT.
REQ-009 SHALL, in IDLE with iStart=1, latch iDecrypt and iRound, set both RAM addresses to 0, go to FETCH; oBusy=1 from next cycle.
REQ-010 SHALL ignore iStart in any state other than IDLE.
REQ-011 SHALL hold addresses stable through FETCH (RAM samples address) and go to WAIT; RAM read latency is exactly 1 cycle.
REQ-012 SHALL, at end of WAIT, register the four words of the selected RAM (m_Kd if latched iDecrypt=1, else m_Ke) into oKey_data_1..4, set oKey_round to current address, go to PRESENT.
REQ-013 SHALL assert oKey_valid only in PRESENT; first oKey_valid occurs 3 cycles after the iStart edge.
REQ-014 SHALL hold oKey_data_*, oKey_round, oKey_last stable while oKey_valid=1 and iKey_ready=0.
REQ-015 SHALL assert oKey_last in PRESENT when address equals latched iRound.
REQ-016 SHALL, on oKey_valid&iKey_ready with oKey_last=0, increment both addresses by 1 and go to FETCH.
REQ-017 SHALL, on oKey_valid&iKey_ready with oKey_last=1, go to IDLE, deassert oBusy and oKey_valid next cycle; addresses hold.
REQ-018 SHALL emit exactly latched iRound+1 keys per sequence; iRound=0 yields one key; addresses never exceed latched iRound (no wrap).
REQ-019 SHALL drive both RAM addresses with identical values; bank selection is on read data only.
REQ-020 SHALL NOT sample iDecrypt or iRound changes after start acceptance.

Reset
REQ-021 SHALL, with iRst_n=0 at a clock edge, go to IDLE and zero oRAM_Ke_addr, oRAM_Kd_addr, oKey_data_1..4, oKey_round, oKey_valid, oKey_last, oBusy.
REQ-022 SHALL abort any sequence on reset mid-operation without emitting further keys; iStart during the reset cycle is ignored.

Structure
REQ-023 SHALL place state encoding, WORD_W/ADDR_W defaults and max round constant 14 in a shared key-schedule package.
REQ-024 SHALL be a single module; no sub-module is required.

Verification
REQ-025 Ke preloaded addr n = {n,n+16,n+32,n+48}; iStart, iDecrypt=0, iRound=10, iKey_ready=1 -> 11 keys, rounds 0..10, first valid 3 cycles after start, oKey_last only on round 10.
REQ-026 Kd preloaded distinct pattern; iDecrypt=1, iRound=14 -> 15 keys from Kd rounds 0..14, Ke data never output.
REQ-027 iRound=12, iKey_ready low 5 cycles on round 4 -> oKey_valid held, data/round 4 stable, addresses unchanged, sequence resumes correctly.
REQ-028 iStart pulsed in PRESENT with iDecrypt toggled -> ignored; sequence completes unaltered from original bank.
REQ-029 iRst_n=0 during WAIT of round 3 -> next cycle all outputs 0, state IDLE; new iStart restarts from round 0.
REQ-030 iRound=0 -> exactly one key, oKey_last=1, oBusy low after acceptance.
